// File: rtl/rng_health_packer.sv
// rng_health_packer: conditions a ring-oscillator entropy bit for the UART.
// Synchronises the raw bit, runs repetition-count and adaptive-proportion
// health tests, Von Neumann de-biases, packs bytes LSB-first and presents
// them through a valid/ready register that drops bytes under back-pressure.
module rng_health_packer #(
    parameter int WARMUP_BITS = 4096,
    parameter int RCT_CUTOFF  = 32,
    parameter int APT_WINDOW  = 1024,
    parameter int APT_CUTOFF  = 600
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        raw_bit,
    output logic [7:0]  out_byte,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [1:0]  health_fail,
    output logic [15:0] drop_count
);

    localparam int WU_W   = $clog2(WARMUP_BITS);
    localparam int RCT_W  = $clog2(RCT_CUTOFF + 1);
    localparam int AIDX_W = $clog2(APT_WINDOW);
    localparam int ACNT_W = $clog2(APT_CUTOFF + 1);

    typedef enum logic [1:0] {WARMUP, RUN, FAIL} state_t;

    state_t            state;
    logic [WU_W-1:0]   wu_cnt;
    logic              sync1, s;
    logic              rct_prev;
    logic [RCT_W-1:0]  rct_run, rct_next;
    logic              apt_ref;
    logic [AIDX_W-1:0] apt_idx;
    logic [ACNT_W-1:0] apt_cnt, apt_next;
    logic              rct_trip, apt_trip, trip;
    logic              phase, pair_a;
    logic [2:0]        bit_idx;
    logic [7:0]        pack_reg, cand_byte;
    logic              accept, cand_valid;

    // Two-flop synchroniser; s is the sample consumed every cycle.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sync1 <= 1'b0;
            s     <= 1'b0;
        end else begin
            sync1 <= raw_bit;
            s     <= sync1;
        end
    end

    // Next-state of both health counters; they saturate at the cutoff so they never wrap.
    always_comb begin
        rct_next = rct_run;
        if (rct_run == '0 || s != rct_prev)
            rct_next = RCT_W'(1);
        else if (rct_run != RCT_W'(RCT_CUTOFF))
            rct_next = rct_run + RCT_W'(1);

        apt_next = apt_cnt;
        if (apt_idx == '0)
            apt_next = ACNT_W'(1);
        else if (s == apt_ref && apt_cnt != ACNT_W'(APT_CUTOFF))
            apt_next = apt_cnt + ACNT_W'(1);

        rct_trip = (rct_next == RCT_W'(RCT_CUTOFF));
        apt_trip = (apt_next == ACNT_W'(APT_CUTOFF));
        // Only the first trip is recorded; once in FAIL the flags are frozen.
        trip     = (rct_trip || apt_trip) && (state != FAIL);
    end

    // Health-test counters and sticky failure flags.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rct_prev    <= 1'b0;
            rct_run     <= '0;
            apt_ref     <= 1'b0;
            apt_idx     <= '0;
            apt_cnt     <= '0;
            health_fail <= 2'b00;
        end else begin
            rct_prev <= s;
            rct_run  <= rct_next;
            apt_cnt  <= apt_next;
            if (apt_idx == '0)
                apt_ref <= s;
            apt_idx <= (apt_idx == AIDX_W'(APT_WINDOW - 1)) ? '0 : apt_idx + AIDX_W'(1);
            if (trip)
                health_fail <= health_fail | {apt_trip, rct_trip};
        end
    end

    // Mode FSM: discard the warm-up samples, run, and latch FAIL until reset.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state  <= WARMUP;
            wu_cnt <= '0;
        end else begin
            case (state)
                WARMUP: begin
                    if (trip)
                        state <= FAIL;
                    else if (wu_cnt == WU_W'(WARMUP_BITS - 1))
                        state <= RUN;
                    else
                        wu_cnt <= wu_cnt + WU_W'(1);
                end
                RUN:     if (trip) state <= FAIL;
                default: state <= FAIL;
            endcase
        end
    end

    // Accepted bit lands at bit_idx; the 8th bit completes the candidate byte.
    always_comb begin
        accept       = phase && (s != pair_a) && (state == RUN);
        cand_byte    = pack_reg;
        cand_byte[bit_idx] = pair_a;
        cand_valid   = accept && (bit_idx == 3'd7);
    end

    // De-bias pairing and byte packing; a trip throws away the partial byte.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            phase    <= 1'b0;
            pair_a   <= 1'b0;
            bit_idx  <= 3'd0;
            pack_reg <= 8'h00;
        end else begin
            phase <= ~phase;
            if (!phase)
                pair_a <= s;
            if (trip) begin
                bit_idx <= 3'd0;
            end else if (accept) begin
                pack_reg <= cand_byte;
                bit_idx  <= bit_idx + 3'd1;
            end
        end
    end

    // Output register: load when free or draining this cycle, otherwise count a drop.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            out_byte   <= 8'h00;
            out_valid  <= 1'b0;
            drop_count <= 16'h0000;
        end else if (trip) begin
            out_valid <= 1'b0;
        end else if (cand_valid) begin
            if (!out_valid || out_ready) begin
                out_byte  <= cand_byte;
                out_valid <= 1'b1;
            end else if (drop_count != 16'hFFFF) begin
                drop_count <= drop_count + 16'd1;
            end
        end else if (out_valid && out_ready) begin
            out_valid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_rng_health_packer.sv
// Bench for rng_health_packer: a stimulus-side model predicts every byte
// (sync delay, pairing, packing, output register) into a queue that the
// monitor drains on each valid&ready transfer; directed checks cover the
// health tests, latency, back-pressure drops and reset.
module tb_rng_health_packer;

    localparam int WARMUP = 4096;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        raw_bit = 1'b0;
    logic        out_ready = 1'b0;
    logic [7:0]  out_byte;
    logic        out_valid;
    logic [1:0]  health_fail;
    logic [15:0] drop_count;

    rng_health_packer dut (
        .clk(clk), .reset(reset), .raw_bit(raw_bit),
        .out_byte(out_byte), .out_valid(out_valid), .out_ready(out_ready),
        .health_fail(health_fail), .drop_count(drop_count)
    );

    always #5 clk = ~clk;

    int n_cmp = 0, n_bad = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Reference model state
    logic        m_s1, m_s2, m_a, alt;
    logic [7:0]  m_byte;
    int          m_idx, m_bit, m_drops, m_cands, n_xfer;
    bit          m_full, m_fail;
    logic [7:0]  q[$];

    // Drive one cycle of stimulus and advance the model across the edge.
    task automatic step(input logic r, input logic rdy);
        logic smp;
        bit   cand;
        raw_bit   = r;
        out_ready = rdy;
        @(posedge clk);
        smp  = m_s2;
        m_s2 = m_s1;
        m_s1 = r;
        cand = 0;
        if (!m_fail) begin
            if (m_idx % 2 == 0) begin
                m_a = smp;
            end else if (m_idx >= WARMUP && smp != m_a) begin
                m_byte[m_bit] = m_a;
                m_bit++;
                if (m_bit == 8) begin
                    cand  = 1;
                    m_bit = 0;
                end
            end
        end
        m_idx++;
        if (cand) begin
            m_cands++;
            if (!m_full || rdy) begin
                q.push_back(m_byte);
                m_full = 1;
            end else if (m_drops < 65535) begin
                m_drops++;
            end
        end else if (m_full && rdy) begin
            m_full = 0;
        end
        #1;
    endtask

    task automatic alt_step(input logic rdy);
        step(alt, rdy);
        alt = ~alt;
    endtask

    // Async reset: outputs must clear without waiting for a clock edge.
    task automatic do_reset();
        reset = 1'b1;
        #1;
        chk("rst_byte",   32'(out_byte),    0);
        chk("rst_valid",  32'(out_valid),   0);
        chk("rst_health", 32'(health_fail), 0);
        chk("rst_drop",   32'(drop_count),  0);
        @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        m_s1 = 0; m_s2 = 0; m_a = 0; m_byte = 0;
        m_idx = 0; m_bit = 0; m_drops = 0; m_cands = 0; n_xfer = 0;
        m_full = 0; m_fail = 0; alt = 1'b1;
        q.delete();
    endtask

    // Monitor: every transfer must match the oldest predicted byte.
    always @(negedge clk) begin
        if (!reset && out_valid && out_ready) begin
            n_xfer++;
            chk("xfer_expected", 32'(q.size() != 0), 1);
            if (q.size() != 0)
                chk("xfer_byte", 32'(out_byte), 32'(q.pop_front()));
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad + 1);
        $fatal(1, "watchdog");
    end

    initial begin
        int n0, c0;
        do_reset();

        // Pattern 1,1,0,0 aligned with pairs: every pair equal, nothing out.
        for (int i = 0; i < WARMUP + 512; i++)
            step(((i >> 1) & 1) == 0, 1'b1);
        chk("t2_valid",  32'(out_valid),   0);
        chk("t2_health", 32'(health_fail), 0);
        chk("t2_drop",   32'(drop_count),  0);
        chk("t2_xfers",  32'(n_xfer),      0);

        // Alternating 1,0: first byte exactly when the 8th RUN pair completes.
        do_reset();
        for (int i = 0; i < WARMUP + 15; i++) alt_step(1'b1);
        chk("t1_lat_before", 32'(out_valid), 0);
        alt_step(1'b1);
        chk("t1_lat_edge", 32'(out_valid), 1);
        chk("t1_byte", 32'(out_byte), 32'hFF);
        n0 = n_xfer;
        for (int i = 0; i < 160; i++) alt_step(1'b1);
        chk("t1_rate", 32'(n_xfer - n0), 10);
        chk("t1_health", 32'(health_fail), 0);

        // Back-pressure: ten byte times stalled keeps the first, drops nine.
        for (int i = 0; i < 4 && m_full; i++) alt_step(1'b1);
        c0 = m_cands;
        for (int i = 0; i < 400 && m_cands < c0 + 10; i++) begin
            alt_step(1'b0);
            if (out_valid) chk("t5_hold", 32'(out_byte), 32'hFF);
        end
        chk("t5_drop",  32'(drop_count), 9);
        chk("t5_valid", 32'(out_valid),  1);
        n0 = n_xfer;
        alt_step(1'b1);
        alt_step(1'b0);
        chk("t5_single", 32'(n_xfer - n0), 1);
        chk("t5_after",  32'(out_valid),   0);
        chk("t5_drop_hold", 32'(drop_count), 9);

        // Reset mid-byte: everything clears, warm-up restarts from scratch.
        for (int i = 0; i < 5; i++) alt_step(1'b1);
        do_reset();
        for (int i = 0; i < WARMUP + 15; i++) alt_step(1'b1);
        chk("t6_lat_before", 32'(out_valid), 0);
        alt_step(1'b1);
        chk("t6_lat_edge", 32'(out_valid), 1);

        // Random entropy with random back-pressure against the model.
        for (int i = 0; i < 1500; i++)
            step(1'($urandom_range(0, 1)), $urandom_range(0, 3) != 0);
        chk("rnd_drop",   32'(drop_count),  32'(m_drops));
        chk("rnd_health", 32'(health_fail), 0);

        // Stuck at 1: RCT trips on the 32nd identical sample.
        step(1'b0, 1'b1);
        for (int i = 0; i < 33; i++) step(1'b1, 1'b1);
        chk("t3_pre", 32'(health_fail), 0);
        step(1'b1, 1'b1);
        m_fail = 1;
        chk("t3_trip",  32'(health_fail), 32'b01);
        chk("t3_valid", 32'(out_valid),   0);
        for (int i = 0; i < 200; i++) alt_step(1'b1);
        chk("t3_sticky", 32'(health_fail), 32'b01);
        chk("t3_valid_hold", 32'(out_valid), 0);

        // Reset while in FAIL, then the 6-of-7 biased pattern trips APT only.
        do_reset();
        for (int i = 0; i < 4 * 1024 && health_fail == 2'b00; i++)
            step(i % 7 != 6, 1'b1);
        m_fail = 1;
        chk("t4_apt", 32'(health_fail), 32'b10);
        chk("t4_valid", 32'(out_valid), 0);
        chk("q_drained", 32'(q.size()), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
